// File: rtl/tl_pkg.sv
// Shared types and helpers for the two-road intersection controller.
// Phase encoding, 7-segment lookup and the countdown width live here.
package tl_pkg;

  localparam int CNT_W = 7;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    ALLRED_A,
    EW_GREEN,
    EW_YELLOW,
    ALLRED_B,
    PED_WALK,
    FLASH
  } phase_e;

  // Active-high segments {dp,g,f,e,d,c,b,a}; non-decimal codes go blank.
  function automatic logic [7:0] seg7(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_if.sv
// Request inputs and lamp/display outputs of the intersection controller.
// The controller takes the master side; the board/bench takes the slave side.
interface traffic_intersection_ctrl_if;

  logic            en;
  logic            ped_req;
  logic            night_mode;
  logic            ns_red;
  logic            ns_yellow;
  logic            ns_green;
  logic            ew_red;
  logic            ew_yellow;
  logic            ew_green;
  logic            ped_walk;
  logic [1:0][7:0] display_led;

  modport master (
    input  en, ped_req, night_mode,
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    output ped_walk, display_led
  );

  modport slave (
    output en, ped_req, night_mode,
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    input  ped_walk, display_led
  );

endinterface

// File: rtl/tl_sec_tick.sv
// Prescaler producing a one-clk tick every pSECOND_CNT_VALUE+1 enabled clocks.
// Holds its count while en is low so a frozen controller resumes mid-second.
module tl_sec_tick #(
  parameter int pSECOND_CNT_VALUE = 99
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (pSECOND_CNT_VALUE < 2) ? 1 : $clog2(pSECOND_CNT_VALUE + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(pSECOND_CNT_VALUE);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TERM) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == TERM);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// NS/EW intersection controller: all-red clearance, pedestrian walk with green
// shortening, night flashing-yellow mode and a two-digit countdown display.
module traffic_intersection_ctrl
  import tl_pkg::*;
#(
  parameter int pSECOND_CNT_VALUE = 99,
  parameter int pGREEN_INIT_VAL   = 14,
  parameter int pYELLOW_INIT_VAL  = 2,
  parameter int pALLRED_INIT_VAL  = 1,
  parameter int pWALK_INIT_VAL    = 9,
  parameter int pPED_SHORT_VAL    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  traffic_intersection_ctrl_if.master bus
);

  if (pGREEN_INIT_VAL < 0 || pGREEN_INIT_VAL > 99 ||
      pYELLOW_INIT_VAL < 0 || pYELLOW_INIT_VAL > 99 ||
      pALLRED_INIT_VAL < 0 || pALLRED_INIT_VAL > 99 ||
      pWALK_INIT_VAL < 0 || pWALK_INIT_VAL > 99 ||
      pPED_SHORT_VAL < 0 || pPED_SHORT_VAL > 99) begin : g_bad_init_val
    $error("traffic_intersection_ctrl: countdown start values must lie in 0..99");
  end

  localparam logic [CNT_W-1:0] GREEN_V  = CNT_W'(pGREEN_INIT_VAL);
  localparam logic [CNT_W-1:0] YELLOW_V = CNT_W'(pYELLOW_INIT_VAL);
  localparam logic [CNT_W-1:0] ALLRED_V = CNT_W'(pALLRED_INIT_VAL);
  localparam logic [CNT_W-1:0] WALK_V   = CNT_W'(pWALK_INIT_VAL);
  localparam logic [CNT_W-1:0] SHORT_V  = CNT_W'(pPED_SHORT_VAL);

  phase_e           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             ped_pending, ped_pending_d;
  logic             blink, blink_d;
  logic             walk_to_ew, walk_to_ew_d;
  logic             enter_walk;
  logic             tick;

  tl_sec_tick #(
    .pSECOND_CNT_VALUE(pSECOND_CNT_VALUE)
  ) u_sec_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (bus.en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ALLRED_B;
      cnt         <= ALLRED_V;
      ped_pending <= 1'b0;
      blink       <= 1'b0;
      walk_to_ew  <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      ped_pending <= ped_pending_d;
      blink       <= blink_d;
      walk_to_ew  <= walk_to_ew_d;
    end
  end

  // walk_to_ew remembers which green the clearance phase was heading for,
  // so a walk phase inserted after either all-red resumes the right road.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    blink_d      = blink;
    walk_to_ew_d = walk_to_ew;
    enter_walk   = 1'b0;
    if (tick) begin
      case (state)
        NS_GREEN, EW_GREEN: begin
          if (cnt == '0) begin
            state_d = (state == NS_GREEN) ? NS_YELLOW : EW_YELLOW;
            cnt_d   = YELLOW_V;
          end else if (ped_pending && (cnt > SHORT_V)) begin
            cnt_d = SHORT_V;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        NS_YELLOW, EW_YELLOW: begin
          if (cnt == '0) begin
            state_d = (state == NS_YELLOW) ? ALLRED_A : ALLRED_B;
            cnt_d   = ALLRED_V;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        ALLRED_A, ALLRED_B: begin
          if (cnt != '0) begin
            cnt_d = cnt - CNT_W'(1);
          end else if (bus.night_mode) begin
            state_d = FLASH;
            cnt_d   = '0;
            blink_d = 1'b0;
          end else if (ped_pending) begin
            state_d      = PED_WALK;
            cnt_d        = WALK_V;
            walk_to_ew_d = (state == ALLRED_A);
            enter_walk   = 1'b1;
          end else begin
            state_d = (state == ALLRED_A) ? EW_GREEN : NS_GREEN;
            cnt_d   = GREEN_V;
          end
        end
        PED_WALK: begin
          if (cnt == '0) begin
            state_d = walk_to_ew ? EW_GREEN : NS_GREEN;
            cnt_d   = GREEN_V;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        FLASH: begin
          if (!bus.night_mode) begin
            state_d = ALLRED_A;
            cnt_d   = ALLRED_V;
          end else begin
            blink_d = ~blink;
          end
        end
        default: begin
          state_d = ALLRED_B;
          cnt_d   = ALLRED_V;
        end
      endcase
    end
    ped_pending_d = bus.ped_req | (ped_pending & ~enter_walk);
  end

  logic            ns_red, ns_yellow, ns_green;
  logic            ew_red, ew_yellow, ew_green;
  logic            ped_walk;
  logic [1:0][7:0] display;
  logic [3:0]      tens, units;

  always_comb begin
    ns_red    = 1'b0;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b0;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    ped_walk  = 1'b0;
    case (state)
      NS_GREEN:  begin ns_green  = 1'b1; ew_red    = 1'b1; end
      NS_YELLOW: begin ns_yellow = 1'b1; ew_red    = 1'b1; end
      EW_GREEN:  begin ns_red    = 1'b1; ew_green  = 1'b1; end
      EW_YELLOW: begin ns_red    = 1'b1; ew_yellow = 1'b1; end
      FLASH:     begin ns_yellow = blink; ew_yellow = blink; end
      PED_WALK:  begin ns_red    = 1'b1; ew_red    = 1'b1; ped_walk = 1'b1; end
      default:   begin ns_red    = 1'b1; ew_red    = 1'b1; end
    endcase
  end

  always_comb begin
    tens  = 4'(cnt / CNT_W'(10));
    units = 4'(cnt % CNT_W'(10));
    if (state == FLASH) begin
      display = {SEG_BLANK, SEG_BLANK};
    end else begin
      display = {seg7(tens), seg7(units)};
    end
  end

  assign bus.ns_red      = ns_red;
  assign bus.ns_yellow   = ns_yellow;
  assign bus.ns_green    = ns_green;
  assign bus.ew_red      = ew_red;
  assign bus.ew_yellow   = ew_yellow;
  assign bus.ew_green    = ew_green;
  assign bus.ped_walk    = ped_walk;
  assign bus.display_led = display;

endmodule
